reg_bank_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer for one shared W-bit flip-flop register.
- NREQ requesters compete for write access. The block grants one requester per transaction, loads its data into the register, and acknowledges it.
- An optional hold window blocks the next grant until the register value has settled for downstream consumers.
- Sits between requester agents and the shared register; the register itself is internal to this block.

---
 rtl/reg_bank_arbiter.sv | 164 ++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter and write sequencer for one shared
// W-bit register. NREQ requesters compete for write access. The block grants
// one requester per transaction, loads its data into the register and
// acknowledges it. After each write it idles for HOLD cycles so the new value
// can settle before the next grant.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous reset, active low
//   req     in   [NREQ]    level request, one bit per requester
//   wdata   in   [NREQ*W]  requester data, slice i = wdata[i*W +: W]
//   clr     in   synchronous clear of q / q_valid
//   ack     out  [NREQ]    one-hot write acknowledge, one cycle wide
//   q       out  [W]       shared register value
//   q_valid out            register holds written data
//   owner   out  [PW]      index of the last requester granted
//   busy    out            high whenever the FSM is not idle
module reg_bank_arbiter #(
  parameter int unsigned W    = 5,
  parameter int unsigned NREQ = 4,
  parameter int unsigned HOLD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*W-1:0]          wdata,
  input  logic                       clr,
  output logic [NREQ-1:0]            ack,
  output logic [W-1:0]               q,
  output logic                       q_valid,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = 4;

  // Counter reload; only meaningful when HOLD > 0.
  localparam logic [CW-1:0] HOLD_INIT = (HOLD > 0) ? CW'(HOLD - 1) : '0;
  localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic            found;
  logic [NREQ-1:0] ack_next;
  logic [W-1:0]    wsel;

  // Round-robin search: first set request at or after ptr, wrapping mod NREQ.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_w;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = PW'(idx);
      if (!found && req[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  // Data slice of the current owner, sampled only at the WRITE closing edge.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == PW'(i)) wsel = wdata[i*W +: W];
    end
  end

  // Next-state logic; ack_next is the one-hot grant loaded on IDLE->WRITE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ack_next   = '0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_next = ST_WRITE;
          for (int i = 0; i < NREQ; i++) begin
            ack_next[i] = (winner == PW'(i));
          end
        end
      end
      ST_WRITE: begin
        if (HOLD > 0) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_INIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Grant bookkeeping and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= '0;
      ptr   <= '0;
      ack   <= '0;
      busy  <= 1'b0;
    end else begin
      ack  <= ack_next;
      busy <= (state_next != ST_IDLE);
      if (state == ST_IDLE && found) begin
        owner <= winner;
      end
      // The just-served requester drops to lowest priority.
      if (state == ST_WRITE) begin
        ptr <= (owner == LAST_REQ) ? '0 : owner + PW'(1);
      end
    end
  end

  // Shared register; clr overrides a coincident load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (state == ST_WRITE) begin
      q       <= wsel;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: one instance with HOLD=2 and one with
// HOLD=0, sharing clock and reset. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point.
module tb_reg_bank_arbiter;

  localparam int unsigned W    = 5;
  localparam int unsigned NREQ = 4;

  logic              clk;
  logic              rst_n;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] wdata;
  logic              clr;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      q;
  logic              q_valid;
  logic [1:0]        owner;
  logic              busy;

  logic [NREQ-1:0]   req1;
  logic [NREQ*W-1:0] wdata1;
  logic              clr1;
  logic [NREQ-1:0]   ack1;
  logic [W-1:0]      q1;
  logic              q_valid1;
  logic [1:0]        owner1;
  logic              busy1;

  int checks;
  int failures;

  reg_bank_arbiter #(.W(W), .NREQ(NREQ), .HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .clr(clr),
    .ack(ack), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
  );

  reg_bank_arbiter #(.W(W), .NREQ(NREQ), .HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req1), .wdata(wdata1), .clr(clr1),
    .ack(ack1), .q(q1), .q_valid(q_valid1), .owner(owner1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] onehot;
    int         exp_idx;
    checks   = 0;
    failures = 0;
    rst_n  = 1'b0;
    req    = '0;
    wdata  = '0;
    clr    = 1'b0;
    req1   = '0;
    wdata1 = '0;
    clr1   = 1'b0;

    // ---- 1: reset state and single write ----
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_qv", 32'(q_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_busy_h0", 32'(busy1), 32'h0);

    wdata[2*W +: W] = 5'h15;
    req = 4'b0100;                       // cycle 0
    tick();                              // cycle 1
    check("t1_ack_c1", 32'(ack), 32'h4);
    check("t1_busy_c1", 32'(busy), 32'h1);
    check("t1_q_c1", 32'(q), 32'h0);
    req = 4'b0000;
    tick();                              // cycle 2
    check("t1_ack_c2", 32'(ack), 32'h0);
    check("t1_q_c2", 32'(q), 32'h15);
    check("t1_qv_c2", 32'(q_valid), 32'h1);
    check("t1_owner_c2", 32'(owner), 32'h2);
    check("t1_busy_c2", 32'(busy), 32'h1);
    tick();                              // cycle 3
    check("t1_busy_c3", 32'(busy), 32'h1);
    tick();                              // cycle 4
    check("t1_busy_c4", 32'(busy), 32'h0);

    // ---- 2: round-robin rotation from a fresh pointer ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) wdata[i*W +: W] = 5'(i + 1);
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      tick();
      onehot = 4'b0001 << i;
      check($sformatf("t2_ack_%0d", i), 32'(ack), 32'(onehot));
      req[i] = 1'b0;
      tick();
      check($sformatf("t2_q_%0d", i), 32'(q), 32'(i + 1));
      check($sformatf("t2_owner_%0d", i), 32'(owner), 32'(i));
      check($sformatf("t2_noack_%0d", i), 32'(ack), 32'h0);
      tick();
      check($sformatf("t2_noack3_%0d", i), 32'(ack), 32'h0);
      tick();
    end

    // ---- 3: two continuous requesters alternate across the wrap ----
    wdata[0*W +: W] = 5'h0C;
    wdata[3*W +: W] = 5'h13;
    req = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      exp_idx = (i % 2 == 0) ? 0 : 3;
      tick();
      onehot = 4'b0001 << exp_idx;
      check($sformatf("t3_ack_%0d", i), 32'(ack), 32'(onehot));
      req[exp_idx] = 1'b0;
      tick();
      req[exp_idx] = 1'b1;
      check($sformatf("t3_owner_%0d", i), 32'(owner), 32'(exp_idx));
      check($sformatf("t3_q_%0d", i), 32'(q), (exp_idx == 0) ? 32'h0C : 32'h13);
      tick();
      tick();
    end
    req = 4'b0000;

    // ---- 4: clr in the WRITE cycle of requester 1 ----
    wdata[1*W +: W] = 5'h1F;
    wdata[2*W +: W] = 5'h0A;
    req = 4'b0110;
    tick();                              // WRITE for requester 1
    check("t4_ack1", 32'(ack), 32'h2);
    req[1] = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_q_clr", 32'(q), 32'h0);
    check("t4_qv_clr", 32'(q_valid), 32'h0);
    check("t4_owner", 32'(owner), 32'h1);
    tick();
    tick();
    tick();
    check("t4_ack2", 32'(ack), 32'h4);
    req[2] = 1'b0;
    tick();
    check("t4_q2", 32'(q), 32'h0A);
    check("t4_qv2", 32'(q_valid), 32'h1);
    tick();
    tick();

    // ---- 5: asynchronous reset during WRITE ----
    req = 4'b0001;
    tick();
    check("t5_ack_pre", 32'(ack), 32'h1);
    #2;
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    check("t5_ack_rst", 32'(ack), 32'h0);
    check("t5_q_rst", 32'(q), 32'h0);
    check("t5_qv_rst", 32'(q_valid), 32'h0);
    check("t5_busy_rst", 32'(busy), 32'h0);
    check("t5_owner_rst", 32'(owner), 32'h0);
    tick();
    rst_n = 1'b1;
    req = 4'b0010;
    tick();
    check("t5_ack_post", 32'(ack), 32'h2);
    check("t5_owner_post", 32'(owner), 32'h1);
    req = 4'b0000;
    tick();
    check("t5_q_post", 32'(q), 32'h1F);
    tick();
    tick();

    // ---- 6: HOLD=0 back-to-back ----
    wdata1[0*W +: W] = 5'h11;
    wdata1[1*W +: W] = 5'h12;
    req1 = 4'b0011;                      // cycle 0
    tick();                              // cycle 1
    check("t6_ack_c1", 32'(ack1), 32'h1);
    check("t6_busy_c1", 32'(busy1), 32'h1);
    req1[0] = 1'b0;
    tick();                              // cycle 2
    check("t6_ack_c2", 32'(ack1), 32'h0);
    check("t6_busy_c2", 32'(busy1), 32'h0);
    check("t6_q_c2", 32'(q1), 32'h11);
    tick();                              // cycle 3
    check("t6_ack_c3", 32'(ack1), 32'h2);
    req1[1] = 1'b0;
    tick();                              // cycle 4
    check("t6_ack_c4", 32'(ack1), 32'h0);
    check("t6_q_c4", 32'(q1), 32'h12);
    check("t6_owner_c4", 32'(owner1), 32'h1);
    tick();
    check("t6_ack_c5", 32'(ack1), 32'h0);
    check("t6_busy_c5", 32'(busy1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
